// File: rtl/pipe_hazard_pkg.sv
// Shared types for the LEGv8 hazard/forwarding unit: scoreboard entries,
// forwarding select encoding and the match helper used by both operands.
package pipe_hazard_pkg;

  // Scoreboard register fields are held at a fixed width; REG_AW must not exceed it.
  localparam int unsigned SB_AW        = 8;
  localparam int unsigned DEF_ZERO_REG = 31;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] rd;
    logic             regwrite;
    logic             memread;
  } sb_entry_t;

  typedef struct packed {
    sb_entry_t        sb;
    logic [SB_AW-1:0] rn;
    logic [SB_AW-1:0] rm;
    logic             use_rn;
    logic             use_rm;
  } ex_entry_t;

  function automatic logic fwd_hit(input logic             wr,
                                   input logic [SB_AW-1:0] rd,
                                   input logic [SB_AW-1:0] src_reg,
                                   input logic             src_use,
                                   input logic [SB_AW-1:0] zero_reg);
    return wr && (rd == src_reg) && (src_reg != zero_reg) && src_use;
  endfunction

endpackage

// File: rtl/hazard_fwd_mux.sv
// Per-operand forwarding: picks MEM over WB over register file for one EX source.
module hazard_fwd_mux
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
  input  logic [SB_AW-1:0]  src_reg,
  input  logic              src_use,
  input  logic              mem_wr,
  input  logic [SB_AW-1:0]  mem_rd,
  input  logic              wb_wr,
  input  logic [SB_AW-1:0]  wb_rd,
  input  logic [DATA_W-1:0] rf_val,
  input  logic [DATA_W-1:0] mem_val,
  input  logic [DATA_W-1:0] wb_val,
  output fwd_sel_t          sel,
  output logic [DATA_W-1:0] val
);

  localparam logic [SB_AW-1:0] ZERO_ID = SB_AW'(ZERO_REG);

  always_comb begin
    sel = FWD_RF;
    if (fwd_hit(mem_wr, mem_rd, src_reg, src_use, ZERO_ID))
      sel = FWD_MEM;
    else if (fwd_hit(wb_wr, wb_rd, src_reg, src_use, ZERO_ID))
      sel = FWD_WB;
  end

  always_comb begin
    case (sel)
      FWD_MEM: val = mem_val;
      FWD_WB:  val = wb_val;
      default: val = rf_val;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush controller for the 5-stage LEGv8 pipeline,
// with an EX/MEM/WB destination scoreboard and saturating event counters.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rn,
  input  logic              id_use_rm,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              mem_branch_taken,
  input  logic [DATA_W-1:0] ex_a_rf,
  input  logic [DATA_W-1:0] ex_b_rf,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_exmem,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [SB_AW-1:0] ZERO_ID = SB_AW'(ZERO_REG);

  ex_entry_t ex_q, ex_d;
  sb_entry_t mem_q, mem_d, wb_q;

  logic [SB_AW-1:0] id_rn_x, id_rm_x;
  logic             stall_raw, stall_eff, flush;
  fwd_sel_t         a_sel, b_sel;

  assign id_rn_x = SB_AW'(id_rn);
  assign id_rm_x = SB_AW'(id_rm);

  assign stall_raw = id_valid && ex_q.sb.valid && ex_q.sb.memread && (ex_q.sb.rd != ZERO_ID) &&
                     ((id_use_rn && (id_rn_x == ex_q.sb.rd)) ||
                      (id_use_rm && (id_rm_x == ex_q.sb.rd)));
  assign flush     = mem_branch_taken;
  // A taken branch squashes the stalled instruction anyway, so the stall is dropped.
  assign stall_eff = stall_raw && !flush;

  assign pc_write    = !stall_eff;
  assign ifid_write  = !stall_eff;
  assign idex_bubble = stall_eff;
  assign flush_ifid  = flush;
  assign flush_idex  = flush;
  assign flush_exmem = flush;

  always_comb begin
    ex_d = '0;
    if (!flush && !stall_eff) begin
      ex_d.sb.valid    = id_valid;
      ex_d.sb.rd       = SB_AW'(id_rd);
      ex_d.sb.regwrite = id_regwrite;
      ex_d.sb.memread  = id_memread;
      ex_d.rn          = id_rn_x;
      ex_d.rm          = id_rm_x;
      ex_d.use_rn      = id_use_rn;
      ex_d.use_rm      = id_use_rm;
    end
    mem_d = flush ? '0 : ex_q.sb;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= mem_q;
      if (stall_eff && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  hazard_fwd_mux #(
    .DATA_W  (DATA_W),
    .ZERO_REG(ZERO_REG)
  ) u_fwd_a (
    .src_reg(ex_q.rn),
    .src_use(ex_q.use_rn),
    .mem_wr (mem_q.valid && mem_q.regwrite),
    .mem_rd (mem_q.rd),
    .wb_wr  (wb_q.valid && wb_q.regwrite),
    .wb_rd  (wb_q.rd),
    .rf_val (ex_a_rf),
    .mem_val(mem_alu_result),
    .wb_val (wb_write_data),
    .sel    (a_sel),
    .val    (ex_a)
  );

  hazard_fwd_mux #(
    .DATA_W  (DATA_W),
    .ZERO_REG(ZERO_REG)
  ) u_fwd_b (
    .src_reg(ex_q.rm),
    .src_use(ex_q.use_rm),
    .mem_wr (mem_q.valid && mem_q.regwrite),
    .mem_rd (mem_q.rd),
    .wb_wr  (wb_q.valid && wb_q.regwrite),
    .wb_rd  (wb_q.rd),
    .rf_val (ex_b_rf),
    .mem_val(mem_alu_result),
    .wb_val (wb_write_data),
    .sel    (b_sel),
    .val    (ex_b)
  );

  assign fwd_a_sel = a_sel;
  assign fwd_b_sel = b_sel;

  // memread is only meaningful in EX; later copies are carried for completeness.
  logic unused_memread;
  assign unused_memread = mem_q.memread ^ wb_q.memread;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: default instance plus a CNT_W=2 instance
// sharing the same stimulus for counter saturation.
module tb_pipe_hazard_unit;

  logic        Clock, Reset_n;
  logic        id_valid, id_use_rn, id_use_rm, id_regwrite, id_memread, mem_branch_taken;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic [63:0] ex_a_rf, ex_b_rf, mem_alu_result, wb_write_data;

  logic        pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [63:0] ex_a, ex_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        d2_pc_write, d2_ifid_write, d2_idex_bubble, d2_flush_ifid, d2_flush_idex, d2_flush_exmem;
  logic [1:0]  d2_fwd_a_sel, d2_fwd_b_sel;
  logic [63:0] d2_ex_a, d2_ex_b;
  logic [1:0]  d2_stall_cnt, d2_flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_unit #(.DATA_W(64), .REG_AW(5), .ZERO_REG(31), .CNT_W(16)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .mem_branch_taken(mem_branch_taken),
    .ex_a_rf(ex_a_rf), .ex_b_rf(ex_b_rf),
    .mem_alu_result(mem_alu_result), .wb_write_data(wb_write_data),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ex_a(ex_a), .ex_b(ex_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_unit #(.DATA_W(64), .REG_AW(5), .ZERO_REG(31), .CNT_W(2)) dut2 (
    .Clock(Clock), .Reset_n(Reset_n), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .mem_branch_taken(mem_branch_taken),
    .ex_a_rf(ex_a_rf), .ex_b_rf(ex_b_rf),
    .mem_alu_result(mem_alu_result), .wb_write_data(wb_write_data),
    .pc_write(d2_pc_write), .ifid_write(d2_ifid_write), .idex_bubble(d2_idex_bubble),
    .flush_ifid(d2_flush_ifid), .flush_idex(d2_flush_idex), .flush_exmem(d2_flush_exmem),
    .fwd_a_sel(d2_fwd_a_sel), .fwd_b_sel(d2_fwd_b_sel), .ex_a(d2_ex_a), .ex_b(d2_ex_b),
    .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                       input logic urn, input logic urm, input logic rw, input logic mr);
    id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd;
    id_use_rn = urn; id_use_rm = urm; id_regwrite = rw; id_memread = mr;
  endtask

  task automatic set_idle();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    mem_branch_taken = 1'b0;
    set_idle();
    ex_a_rf = 64'hAAAA; ex_b_rf = 64'hBBBB;
    mem_alu_result = 64'h10; wb_write_data = 64'h20;
    #2;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL reset_pc_write got %0h exp 1", pc_write); end
    checks++; if (ifid_write !== 1'b1) begin errors++; $display("FAIL reset_ifid_write got %0h exp 1", ifid_write); end
    checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %0h exp 0", idex_bubble); end
    checks++; if ({flush_ifid, flush_idex, flush_exmem} !== 3'b000) begin errors++;
      $display("FAIL reset_flush got %0b exp 000", {flush_ifid, flush_idex, flush_exmem}); end
    checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin errors++;
      $display("FAIL reset_sels got %0b exp 0000", {fwd_a_sel, fwd_b_sel}); end
    checks++; if (ex_a !== 64'hAAAA || ex_b !== 64'hBBBB) begin errors++;
      $display("FAIL reset_operands got %0h/%0h exp aaaa/bbbb", ex_a, ex_b); end
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++;
      $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    step(); step();
    Reset_n = 1'b1;
    step(); step();
  endtask

  task automatic test_fwd_mem();
    issue(1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);   // ADD X1,X2,X3
    step();
    issue(1'b1, 5'd1, 5'd5, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);   // SUB X4,X1,X5
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL fwd_mem_nostall got %0h exp 1", pc_write); end
    step();
    set_idle();
    #1;
    checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL fwd_mem_sel_a got %0b exp 10", fwd_a_sel); end
    checks++; if (ex_a !== 64'h10) begin errors++; $display("FAIL fwd_mem_ex_a got %0h exp 10", ex_a); end
    checks++; if (fwd_b_sel !== 2'b00 || ex_b !== 64'hBBBB) begin errors++;
      $display("FAIL fwd_mem_b got %0b/%0h exp 00/bbbb", fwd_b_sel, ex_b); end
    step(); step(); step();
  endtask

  task automatic test_load_use();
    issue(1'b1, 5'd2, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);   // LDUR X1,[X2]
    step();
    issue(1'b1, 5'd1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);   // ADD X2,X1,X3
    #1;
    checks++; if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin errors++;
      $display("FAIL load_use_stall got %0b exp 001", {pc_write, ifid_write, idex_bubble}); end
    step();
    #1;
    checks++; if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin errors++;
      $display("FAIL load_use_release got %0b exp 110", {pc_write, ifid_write, idex_bubble}); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL load_use_cnt got %0d exp 1", stall_cnt); end
    step();
    set_idle();
    #1;
    checks++; if (fwd_a_sel !== 2'b01 || ex_a !== 64'h20) begin errors++;
      $display("FAIL load_use_fwd_wb got %0b/%0h exp 01/20", fwd_a_sel, ex_a); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL load_use_b got %0b exp 00", fwd_b_sel); end
    step(); step(); step();
  endtask

  task automatic test_zero_reg();
    issue(1'b1, 5'd2, 5'd3, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0);  // ADD XZR
    step();
    issue(1'b1, 5'd2, 5'd0, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1);  // LDUR XZR
    step();
    issue(1'b1, 5'd31, 5'd31, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0); // ADD X9,XZR,XZR
    #1;
    checks++; if ({pc_write, idex_bubble} !== 2'b10) begin errors++;
      $display("FAIL zero_nostall got %0b exp 10", {pc_write, idex_bubble}); end
    step();
    set_idle();
    #1;
    checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000 || ex_a !== 64'hAAAA) begin errors++;
      $display("FAIL zero_sels got %0b/%0h exp 0000/aaaa", {fwd_a_sel, fwd_b_sel}, ex_a); end
    step(); step(); step();
  endtask

  task automatic test_mem_priority();
    issue(1'b1, 5'd2, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    issue(1'b1, 5'd4, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    issue(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    set_idle();
    #1;
    checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin errors++;
      $display("FAIL prio_sels got %0b exp 1010", {fwd_a_sel, fwd_b_sel}); end
    checks++; if (ex_a !== 64'h10 || ex_b !== 64'h10) begin errors++;
      $display("FAIL prio_vals got %0h/%0h exp 10/10", ex_a, ex_b); end
    step(); step(); step();
  endtask

  task automatic test_flush_over_stall();
    issue(1'b1, 5'd2, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    issue(1'b1, 5'd1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    mem_branch_taken = 1'b1;
    #1;
    checks++; if ({flush_ifid, flush_idex, flush_exmem} !== 3'b111) begin errors++;
      $display("FAIL flush_outs got %0b exp 111", {flush_ifid, flush_idex, flush_exmem}); end
    checks++; if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin errors++;
      $display("FAIL flush_over_stall got %0b exp 110", {pc_write, ifid_write, idex_bubble}); end
    step();
    mem_branch_taken = 1'b0;
    #1;
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin errors++;
      $display("FAIL flush_counts got %0d/%0d exp 1/1", flush_cnt, stall_cnt); end
    checks++; if ({flush_ifid, pc_write} !== 2'b01) begin errors++;
      $display("FAIL flush_after got %0b exp 01", {flush_ifid, pc_write}); end
    set_idle();
    step(); step(); step();
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 5; i++) begin
      issue(1'b1, 5'd2, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      issue(1'b1, 5'd1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      set_idle();
      step(); step();
      checks++; if (d2_stall_cnt !== ((i + 1 > 3) ? 2'd3 : 2'(i + 1))) begin errors++;
        $display("FAIL sat_cnt2_%0d got %0d exp %0d", i, d2_stall_cnt, (i + 1 > 3) ? 3 : i + 1); end
      checks++; if (stall_cnt !== 16'(i + 1)) begin errors++;
        $display("FAIL sat_cnt16_%0d got %0d exp %0d", i, stall_cnt, i + 1); end
    end
  endtask

  task automatic test_reset_mid_stall();
    issue(1'b1, 5'd2, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    issue(1'b1, 5'd1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rst_pre_stall got %0h exp 0", pc_write); end
    Reset_n = 1'b0;
    #1;
    checks++; if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin errors++;
      $display("FAIL rst_ctrl got %0b exp 110", {pc_write, ifid_write, idex_bubble}); end
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || d2_stall_cnt !== 2'd0) begin errors++;
      $display("FAIL rst_counters got %0d/%0d/%0d exp 0/0/0", stall_cnt, flush_cnt, d2_stall_cnt); end
    checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000 || ex_b !== 64'hBBBB) begin errors++;
      $display("FAIL rst_fwd got %0b/%0h exp 0000/bbbb", {fwd_a_sel, fwd_b_sel}, ex_b); end
    step();
    Reset_n = 1'b1;
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rst_no_pending got %0h exp 1", pc_write); end
    step();
    set_idle();
  endtask

  initial begin
    test_reset();
    test_fwd_mem();
    test_load_use();
    test_zero_reg();
    test_mem_priority();
    test_flush_over_stall();
    test_saturation();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
